// File: rtl/led_activity_if.sv
// Host register-write bus shared with the OPL3 core.
// The master drives writes; led_activity listens on the slave side.
interface led_activity_if;
  logic       valid;
  logic       bank_num;
  logic [7:0] address;
  logic [7:0] data;

  modport master (output valid, bank_num, address, data);
  modport slave  (input  valid, bank_num, address, data);
endinterface

// File: rtl/led_activity.sv
// Key-on tracker for all 18 OPL3 channels, folded onto NUM_LEDS outputs.
// Each LED is driven in level, pulse-stretch, PWM-dimmed level or off mode.
module led_activity #(
  parameter int NUM_LEDS    = 9,
  parameter int HOLD_CYCLES = 1000000,
  parameter int PWM_BITS    = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  led_activity_if.slave       opl3_reg_wr,
  input  logic [1:0]          mode,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [NUM_LEDS-1:0] led,
  output logic [17:0]         key_on_state
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  logic [17:0]         r_key_on;
  logic [PWM_BITS-1:0] r_pwm;
  logic [NUM_LEDS-1:0] r_led;

  logic                w_chan_wr;
  logic [4:0]          w_chan;
  logic [17:0]         w_chan_sel;
  logic [17:0]         w_rise;
  logic [NUM_LEDS-1:0] w_lvl;
  logic [NUM_LEDS-1:0] w_hit;
  logic [NUM_LEDS-1:0] w_busy;
  logic                w_pwm_on;
  logic [NUM_LEDS-1:0] w_led_next;

  // Inside B0h..B8h the channel offset is simply the low address nibble.
  assign w_chan_wr  = opl3_reg_wr.valid &&
                      (opl3_reg_wr.address >= 8'hB0) &&
                      (opl3_reg_wr.address <= 8'hB8);
  assign w_chan     = (opl3_reg_wr.bank_num ? 5'd9 : 5'd0) + {1'b0, opl3_reg_wr.address[3:0]};
  assign w_chan_sel = w_chan_wr ? (18'd1 << w_chan) : 18'd0;
  assign w_rise     = opl3_reg_wr.data[5] ? (w_chan_sel & ~r_key_on) : 18'd0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_key_on <= '0;
    end else if (opl3_reg_wr.data[5]) begin
      r_key_on <= r_key_on | w_chan_sel;
    end else begin
      r_key_on <= r_key_on & ~w_chan_sel;
    end
  end

  function automatic logic [17:0] led_mask(input int idx);
    logic [17:0] m;
    m = '0;
    for (int c = 0; c < 18; c++) begin
      if ((c % NUM_LEDS) == idx) m = m | (18'd1 << c);
    end
    return m;
  endfunction

  // Channels sharing an LED share one stretch counter; any rising edge reloads it.
  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_led
    localparam logic [17:0] MASK = led_mask(i);
    logic [CNT_W-1:0] r_hold;

    assign w_lvl[i]  = |(r_key_on & MASK);
    assign w_hit[i]  = |(w_rise & MASK);
    assign w_busy[i] = (r_hold != '0);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_hold <= '0;
      end else if (w_hit[i]) begin
        r_hold <= CNT_W'(HOLD_CYCLES);
      end else if (r_hold != '0) begin
        r_hold <= r_hold - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pwm <= '0;
    end else begin
      r_pwm <= r_pwm + 1'b1;
    end
  end

  assign w_pwm_on = (r_pwm < brightness);

  always_comb begin
    w_led_next = '0;
    case (mode)
      2'd0:    w_led_next = w_lvl;
      2'd1:    w_led_next = w_busy;
      2'd2:    w_led_next = w_lvl & {NUM_LEDS{w_pwm_on}};
      default: w_led_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_led <= '0;
    end else begin
      r_led <= w_led_next;
    end
  end

  assign led          = r_led;
  assign key_on_state = r_key_on;

endmodule

// File: tb/tb_led_activity.sv
// Directed bench for led_activity with NUM_LEDS=4, HOLD_CYCLES=8, PWM_BITS=3.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_led_activity;
  localparam int NL = 4;
  localparam int HC = 8;
  localparam int PB = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [PB-1:0] brightness = '0;
  logic [NL-1:0] led;
  logic [17:0]   key_on_state;
  int            total = 0;
  int            bad = 0;

  led_activity_if bus();

  led_activity #(.NUM_LEDS(NL), .HOLD_CYCLES(HC), .PWM_BITS(PB)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .opl3_reg_wr  (bus),
    .mode         (mode),
    .brightness   (brightness),
    .led          (led),
    .key_on_state (key_on_state)
  );

  always #5 clk = ~clk;

  // One write, sampled by the next rising edge; returns on the following falling edge.
  task automatic applyStimulus(input logic bank, input logic [7:0] addr, input logic [7:0] data);
    bus.valid    = 1'b1;
    bus.bank_num = bank;
    bus.address  = addr;
    bus.data     = data;
    @(negedge clk);
    bus.valid    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle(2);
    total++; if (led !== 4'b0000) begin $display("[TB] FAIL reset_led got=%b want=0000", led); bad++; end
    total++; if (key_on_state !== 18'h0) begin $display("[TB] FAIL reset_key got=%h want=00000", key_on_state); bad++; end
    reset_n = 1'b1;
    idle(1);
  endtask

  task automatic test_decode();
    mode = 2'd0;
    applyStimulus(1'b0, 8'hB0, 8'h20);
    total++; if (key_on_state !== 18'h00001) begin $display("[TB] FAIL decode_key0 got=%h want=00001", key_on_state); bad++; end
    idle(1);
    total++; if (led !== 4'b0001) begin $display("[TB] FAIL decode_led0 got=%b want=0001", led); bad++; end
    applyStimulus(1'b1, 8'hB2, 8'h20);
    total++; if (key_on_state !== 18'h00801) begin $display("[TB] FAIL decode_key11 got=%h want=00801", key_on_state); bad++; end
    idle(1);
    total++; if (led !== 4'b1001) begin $display("[TB] FAIL decode_led11 got=%b want=1001", led); bad++; end
    applyStimulus(1'b0, 8'hB9, 8'h20);
    applyStimulus(1'b0, 8'hA0, 8'h20);
    applyStimulus(1'b1, 8'hBD, 8'h20);
    idle(1);
    total++; if (key_on_state !== 18'h00801) begin $display("[TB] FAIL decode_ignore_key got=%h want=00801", key_on_state); bad++; end
    total++; if (led !== 4'b1001) begin $display("[TB] FAIL decode_ignore_led got=%b want=1001", led); bad++; end
    applyStimulus(1'b0, 8'hB0, 8'h00);
    applyStimulus(1'b1, 8'hB2, 8'h00);
    idle(1);
    total++; if (key_on_state !== 18'h0) begin $display("[TB] FAIL decode_off_key got=%h want=00000", key_on_state); bad++; end
    total++; if (led !== 4'b0000) begin $display("[TB] FAIL decode_off_led got=%b want=0000", led); bad++; end
  endtask

  task automatic test_folding();
    applyStimulus(1'b0, 8'hB1, 8'h20);
    applyStimulus(1'b0, 8'hB5, 8'h20);
    idle(1);
    total++; if (led !== 4'b0010) begin $display("[TB] FAIL fold_both got=%b want=0010", led); bad++; end
    applyStimulus(1'b0, 8'hB1, 8'h00);
    idle(1);
    total++; if (led[1] !== 1'b1) begin $display("[TB] FAIL fold_one_left got=%b want=1", led[1]); bad++; end
    applyStimulus(1'b0, 8'hB5, 8'h00);
    idle(1);
    total++; if (led[1] !== 1'b0) begin $display("[TB] FAIL fold_all_off got=%b want=0", led[1]); bad++; end
  endtask

  task automatic test_stretch();
    mode = 2'd1;
    idle(HC + 2);
    total++; if (led !== 4'b0000) begin $display("[TB] FAIL stretch_idle got=%b want=0000", led); bad++; end
    // Single pulse: high for exactly HC samples, then low.
    applyStimulus(1'b0, 8'hB2, 8'h20);
    for (int k = 0; k < HC + 4; k++) begin
      idle(1);
      total++; if (led[2] !== logic'(k < HC)) begin $display("[TB] FAIL stretch_single k=%0d got=%b want=%b", k, led[2], logic'(k < HC)); bad++; end
    end
    // Key-off then key-on five cycles into a pulse reloads the full length.
    applyStimulus(1'b0, 8'hB2, 8'h00);
    applyStimulus(1'b0, 8'hB2, 8'h20);
    idle(4);
    applyStimulus(1'b0, 8'hB2, 8'h00);
    total++; if (led[2] !== 1'b1) begin $display("[TB] FAIL stretch_keyoff got=%b want=1", led[2]); bad++; end
    applyStimulus(1'b0, 8'hB2, 8'h20);
    total++; if (led[2] !== 1'b1) begin $display("[TB] FAIL stretch_rekey got=%b want=1", led[2]); bad++; end
    for (int k = 0; k < HC; k++) begin
      idle(1);
      total++; if (led[2] !== 1'b1) begin $display("[TB] FAIL stretch_retrig k=%0d got=%b want=1", k, led[2]); bad++; end
    end
    idle(1);
    total++; if (led[2] !== 1'b0) begin $display("[TB] FAIL stretch_retrig_end got=%b want=0", led[2]); bad++; end
    // Repeated key-on while already on must not reload.
    applyStimulus(1'b0, 8'hB2, 8'h00);
    applyStimulus(1'b0, 8'hB2, 8'h20);
    idle(4);
    applyStimulus(1'b0, 8'hB2, 8'h20);
    total++; if (led[2] !== 1'b1) begin $display("[TB] FAIL norel_during got=%b want=1", led[2]); bad++; end
    idle(3);
    total++; if (led[2] !== 1'b1) begin $display("[TB] FAIL norel_last got=%b want=1", led[2]); bad++; end
    idle(1);
    total++; if (led[2] !== 1'b0) begin $display("[TB] FAIL norel_end got=%b want=0", led[2]); bad++; end
  endtask

  task automatic test_pwm();
    int hi0;
    int hi1;
    int hi2;
    mode = 2'd2;
    brightness = 3'd3;
    applyStimulus(1'b0, 8'hB0, 8'h20);
    idle(2);
    hi0 = 0; hi2 = 0;
    for (int k = 0; k < 8; k++) begin
      idle(1);
      hi0 += int'(led[0]);
      hi2 += int'(led[2]);
    end
    total++; if (hi0 !== 3) begin $display("[TB] FAIL pwm_b3_led0 got=%0d want=3", hi0); bad++; end
    total++; if (hi2 !== 3) begin $display("[TB] FAIL pwm_b3_led2 got=%0d want=3", hi2); bad++; end
    brightness = 3'd0;
    idle(2);
    hi0 = 0;
    for (int k = 0; k < 16; k++) begin
      idle(1);
      hi0 += int'(led[0]);
    end
    total++; if (hi0 !== 0) begin $display("[TB] FAIL pwm_b0 got=%0d want=0", hi0); bad++; end
    brightness = 3'd7;
    idle(2);
    hi0 = 0; hi1 = 0;
    for (int k = 0; k < 8; k++) begin
      idle(1);
      hi0 += int'(led[0]);
      hi1 += int'(led[1]);
    end
    total++; if (hi0 !== 7) begin $display("[TB] FAIL pwm_b7 got=%0d want=7", hi0); bad++; end
    total++; if (hi1 !== 0) begin $display("[TB] FAIL pwm_b7_unkeyed got=%0d want=0", hi1); bad++; end
  endtask

  task automatic test_mode_switch();
    mode = 2'd3;
    for (int b = 0; b < 2; b++) begin
      for (int a = 0; a < 9; a++) begin
        applyStimulus(logic'(b), 8'hB0 + 8'(a), 8'h20);
      end
    end
    idle(1);
    total++; if (key_on_state !== 18'h3FFFF) begin $display("[TB] FAIL mode3_key got=%h want=3ffff", key_on_state); bad++; end
    total++; if (led !== 4'b0000) begin $display("[TB] FAIL mode3_led got=%b want=0000", led); bad++; end
    mode = 2'd0;
    idle(1);
    total++; if (led !== 4'b1111) begin $display("[TB] FAIL mode0_switch got=%b want=1111", led); bad++; end
  endtask

  task automatic test_async_reset();
    mode = 2'd1;
    applyStimulus(1'b0, 8'hB3, 8'h00);
    idle(HC + 2);
    total++; if (led !== 4'b0000) begin $display("[TB] FAIL arst_pre got=%b want=0000", led); bad++; end
    applyStimulus(1'b0, 8'hB3, 8'h20);
    idle(2);
    total++; if (led[3] !== 1'b1) begin $display("[TB] FAIL arst_pulse got=%b want=1", led[3]); bad++; end
    #2 reset_n = 1'b0;
    #1;
    total++; if (led !== 4'b0000) begin $display("[TB] FAIL arst_led_now got=%b want=0000", led); bad++; end
    total++; if (key_on_state !== 18'h0) begin $display("[TB] FAIL arst_key_now got=%h want=00000", key_on_state); bad++; end
    bus.valid = 1'b1; bus.bank_num = 1'b0; bus.address = 8'hB4; bus.data = 8'h20;
    idle(2);
    bus.valid = 1'b0;
    total++; if (key_on_state !== 18'h0) begin $display("[TB] FAIL arst_bus_ignored got=%h want=00000", key_on_state); bad++; end
    reset_n = 1'b1;
    for (int k = 0; k < HC + 2; k++) begin
      idle(1);
      total++; if (led !== 4'b0000 || key_on_state !== 18'h0) begin $display("[TB] FAIL arst_after k=%0d led=%b key=%h want led=0000 key=00000", k, led, key_on_state); bad++; end
    end
    applyStimulus(1'b0, 8'hB3, 8'h20);
    total++; if (key_on_state !== 18'h00008) begin $display("[TB] FAIL arst_first_key got=%h want=00008", key_on_state); bad++; end
    idle(1);
    total++; if (led !== 4'b1000) begin $display("[TB] FAIL arst_first_led got=%b want=1000", led); bad++; end
  endtask

  initial begin
    bus.valid = 1'b0; bus.bank_num = 1'b0; bus.address = 8'h00; bus.data = 8'h00;
    @(negedge clk);
    test_reset();
    test_decode();
    test_folding();
    test_stretch();
    test_pwm();
    test_mode_switch();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
